// File: rtl/sync_fifo_hs.sv
// Single-clock FIFO with valid/ready handshake on both sides, first-word-fall-through
// output, occupancy count, programmable almost-full/almost-empty flags and synchronous flush.
module sync_fifo_hs #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic                                 clock,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
  output logic                                 almost_full,
  output logic                                 almost_empty
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop;

  // Handshake status comes only from the count register, never from in_valid/out_ready.
  assign in_ready     = (count_q < CW'(FIFO_DEPTH));
  assign out_valid    = (count_q != '0);
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign count        = count_q;
  assign out_data     = out_valid ? mem_q[rptr_q] : '0;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next-state for pointers and occupancy; flush overrides any push/pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wptr_d = (wptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = (rptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem_q[wptr_q] <= in_data;
    end
  end

  a_count_bound : assert property (@(posedge clock) disable iff (!rst)
    count_q <= CW'(FIFO_DEPTH));

  a_head_stable : assert property (@(posedge clock) disable iff (!rst)
    (out_valid && !out_ready && !flush) |=> $stable(out_data));

endmodule

// File: tb/tb_sync_fifo_hs.sv
// Bench for sync_fifo_hs: a depth-8 and a depth-5 instance share stimulus; a queue model
// per instance is compared every cycle, plus hand-computed literal checks.
module tb_sync_fifo_hs;

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_af, a_ae;
  logic [63:0] a_out_data;
  logic [3:0]  a_count;
  logic        b_in_ready, b_out_valid, b_af, b_ae;
  logic [15:0] b_out_data;
  logic [2:0]  b_count;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  always #5 clock = ~clock;

  sync_fifo_hs #(.DATA_WIDTH(64), .FIFO_DEPTH(8)) dut_a (
    .clock(clock), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .count(a_count), .almost_full(a_af), .almost_empty(a_ae)
  );

  sync_fifo_hs #(.DATA_WIDTH(16), .FIFO_DEPTH(5), .AF_THRESH(3), .AE_THRESH(2)) dut_b (
    .clock(clock), .rst(rst), .flush(flush),
    .in_data(in_data[15:0]), .in_valid(in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .count(b_count), .almost_full(b_af), .almost_empty(b_ae)
  );

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each FIFO is just a bounded queue.
  logic [63:0] qa[$];
  logic [15:0] qb[$];

  always @(posedge clock or negedge rst) begin : model
    bit pa, oa, pb, ob;
    if (!rst) begin
      qa.delete();
      qb.delete();
    end else if (flush) begin
      qa.delete();
      qb.delete();
    end else begin
      pa = in_valid && (qa.size() < 8);
      oa = out_ready && (qa.size() > 0);
      pb = in_valid && (qb.size() < 5);
      ob = out_ready && (qb.size() > 0);
      if (oa) void'(qa.pop_front());
      if (pa) qa.push_back(in_data);
      if (ob) void'(qb.pop_front());
      if (pb) qb.push_back(in_data[15:0]);
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      cmp("a_count",     64'(a_count),     64'(qa.size()));
      cmp("a_in_ready",  64'(a_in_ready),  64'(qa.size() < 8));
      cmp("a_out_valid", 64'(a_out_valid), 64'(qa.size() > 0));
      cmp("a_out_data",  a_out_data,       (qa.size() > 0) ? qa[0] : 64'd0);
      cmp("a_af",        64'(a_af),        64'(qa.size() >= 7));
      cmp("a_ae",        64'(a_ae),        64'(qa.size() <= 1));
      cmp("b_count",     64'(b_count),     64'(qb.size()));
      cmp("b_in_ready",  64'(b_in_ready),  64'(qb.size() < 5));
      cmp("b_out_valid", 64'(b_out_valid), 64'(qb.size() > 0));
      cmp("b_out_data",  64'(b_out_data),  (qb.size() > 0) ? 64'(qb[0]) : 64'd0);
      cmp("b_af",        64'(b_af),        64'(qb.size() >= 3));
      cmp("b_ae",        64'(b_ae),        64'(qb.size() <= 2));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    cmp({tag, "_count"},     64'(a_count),     64'd0);
    cmp({tag, "_in_ready"},  64'(a_in_ready),  64'd1);
    cmp({tag, "_out_valid"}, 64'(a_out_valid), 64'd0);
    cmp({tag, "_out_data"},  a_out_data,       64'd0);
    cmp({tag, "_ae"},        64'(a_ae),        64'd1);
    cmp({tag, "_af"},        64'(a_af),        64'd0);
  endtask

  initial begin
    repeat (2) step();
    reset_checks("rst0");
    rst = 1'b1;
    step();
    check_en = 1'b1;

    // Fill depth-8 with 0x10..0x17, then try a 9th push.
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data = 64'(32'h10 + i);
      step();
      cmp("fill_af", 64'(a_af), 64'((i + 1) >= 7));
    end
    cmp("full_count", 64'(a_count), 64'd8);
    cmp("full_in_ready", 64'(a_in_ready), 64'd0);
    in_data = 64'h18;
    step();
    cmp("ninth_count", 64'(a_count), 64'd8);
    in_valid = 1'b0;

    // Drain in order.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmp("drain_data", a_out_data, 64'(32'h10 + i));
      step();
    end
    cmp("empty_valid", 64'(a_out_valid), 64'd0);
    cmp("empty_data",  a_out_data,       64'd0);
    cmp("empty_count", 64'(a_count),     64'd0);
    cmp("empty_ae",    64'(a_ae),        64'd1);

    // Steady state at count=4 with simultaneous push and pop.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 64'(32'h20 + i);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 64'(32'h24 + i);
      cmp("stream_data", a_out_data, 64'(32'h20 + i));
      step();
      cmp("stream_count", 64'(a_count), 64'd4);
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Depth-5 wrap: push 5, pop 3, push 3, pop 5.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 64'(32'h30 + i);
      step();
    end
    cmp("wrap_c5a", 64'(b_count), 64'd5);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    cmp("wrap_c2", 64'(b_count), 64'd2);
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 64'(32'h35 + i);
      step();
    end
    cmp("wrap_c5b", 64'(b_count), 64'd5);
    cmp("wrap_in_ready", 64'(b_in_ready), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmp("wrap_data", 64'(b_out_data), 64'(32'h33 + i));
      step();
    end
    cmp("wrap_c0", 64'(b_count), 64'd0);
    repeat (3) step();

    // Flush at count=6 with a competing push of 0xAA.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 64'(32'h40 + i);
      step();
    end
    cmp("pre_flush_count", 64'(a_count), 64'd6);
    flush = 1'b1;
    in_data = 64'hAA;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    cmp("flush_count", 64'(a_count), 64'd0);
    cmp("flush_valid", 64'(a_out_valid), 64'd0);
    cmp("flush_b_count", 64'(b_count), 64'd0);
    in_valid = 1'b1;
    in_data = 64'h77;
    step();
    in_valid = 1'b0;
    cmp("post_flush_a", a_out_data, 64'h77);
    cmp("post_flush_b", 64'(b_out_data), 64'h77);
    out_ready = 1'b1;
    step();

    // Asynchronous reset at count=3.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 64'(32'h60 + i);
      step();
    end
    in_valid = 1'b0;
    cmp("pre_rst_count", 64'(a_count), 64'd3);
    rst = 1'b0;
    #1;
    reset_checks("async_rst");
    step();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 64'h55;
    step();
    in_valid = 1'b0;
    cmp("after_rst_data", a_out_data, 64'h55);
    cmp("after_rst_count", 64'(a_count), 64'd1);
    out_ready = 1'b1;
    repeat (2) step();

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_hs.md
Name: sync_fifo_hs

Overview:
- Single-clock FIFO with valid/ready handshake on both sides; successor to the plain wr_en/rd_en sync FIFO.
- All FIFO_DEPTH entries are usable; no data loss (push only when in_ready, pop only when out_valid).
- First-word-fall-through output, occupancy count, programmable almost-full/almost-empty flags, synchronous flush.
- Non-power-of-2 depths are supported. Sits between producer/consumer pipeline stages in the same clock domain.

Parameters:
- DATA_WIDTH, 64, entry width in bits (>=1)
- FIFO_DEPTH, 8, number of entries (>=2, any integer)
- AF_THRESH, FIFO_DEPTH-1, almost_full asserted when count >= AF_THRESH (1..FIFO_DEPTH)
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..FIFO_DEPTH-1)

Ports:
- clock  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous clear of contents
- in_data  input  DATA_WIDTH  write data
- in_valid  input  1  producer has data
- in_ready  output  1  FIFO can accept (count < FIFO_DEPTH)
- out_data  output  DATA_WIDTH  head entry (FWFT); 0 when out_valid=0
- out_valid  output  1  FIFO non-empty (count > 0)
- out_ready  input  1  consumer accepts head
- count  output  $clog2(FIFO_DEPTH+1)  current occupancy
- almost_full  output  1  count >= AF_THRESH
- almost_empty  output  1  count <= AE_THRESH

Behaviour:
- Reset is rst, asynchronous, active-low; clock is clock.
- Reset values: wptr=rptr=0, count=0, in_ready=1, out_valid=0, out_data=0, almost_empty=1, almost_full=0. Storage array is not reset.
- push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated each rising edge.
- push: mem[wptr]<=in_data; wptr advances. pop: rptr advances. Pointer width is $clog2(FIFO_DEPTH) (min 1). Each pointer wraps to 0 after FIFO_DEPTH-1; no reliance on natural binary overflow.
- count register: +1 on push only, -1 on pop only, unchanged on push&pop or neither.
- in_ready, out_valid, almost_full and almost_empty are decoded from the count register only. There is no combinational path from in_valid/out_ready to any output.
- out_data = mem[rptr] combinationally when out_valid, else 0.
- Write-to-read latency: data pushed at edge N is visible on out_data/out_valid after edge N; pop possible at edge N+1.
- Empty with in_valid=1: no pop that cycle (out_valid=0); no bypass.
- Full: in_ready=0 even if out_ready=1 (no pass-through). A pop that cycle frees a slot; in_ready=1 from the next cycle.
- Simultaneous push&pop with 0<count<FIFO_DEPTH: both occur; count unchanged; ordering preserved.
- flush=1 at an edge: wptr=rptr=count=0, taking priority over push/pop that cycle. The in_data presented that cycle is discarded. Outputs then show the reset values.
- Asynchronous reset mid-operation: immediate return to reset values; contents are lost. The first push after rst deassert lands at index 0.
- Simulation assertions: count never exceeds FIFO_DEPTH; out_data is stable while out_valid & !out_ready.

Test Plan:
- DEPTH=8, reset then push 0x10..0x17 on 8 consecutive cycles with out_ready=0 -> count=8, in_ready=0, almost_full=1 from count=7; a 9th push of 0x18 is not accepted.
- Drain the full FIFO with out_ready=1 -> out_data 0x10..0x17 in order, one per cycle; then out_valid=0, out_data=0, count=0, almost_empty=1.
- count=4, in_valid=out_ready=1 for 10 cycles with incrementing data -> count stays 4, output sequence is strictly in order.
- DEPTH=5: push 5, pop 3, push 3, pop 5 -> pointers wrap at 4->0, data order preserved, count sequence 5,2,5,0.
- count=6: assert flush together with in_valid=1 (data 0xAA) -> next cycle count=0, out_valid=0; 0xAA never appears; the next push is read back correctly.
- Drop rst mid-stream at count=3 -> outputs return to reset values asynchronously (before the next edge); after release, pushing 0x55 gives out_data=0x55 one edge later.
